line_sched: RTL and testbench

LINE_SCHED -- requirements
Module: line_sched

---
 rtl/line_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/line_sched.sv | 164 ++++++++++++++++
 tb/tb_line_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_sched_pkg.sv
// Shared types and defaults for the line scheduler: FSM states, coordinate
// widths and the line endpoint record.
package line_sched_pkg;

  localparam int XW_DEF = 11;
  localparam int YW_DEF = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4
  } state_t;

  typedef struct packed {
    logic [XW_DEF-1:0] x0;
    logic [YW_DEF-1:0] y0;
    logic [XW_DEF-1:0] x1;
    logic [YW_DEF-1:0] y1;
  } line_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at index ptr and wraps,
// the first set request wins and is returned one-hot.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_sched.sv
// Frame-based line request scheduler feeding a single line engine.
// Optional engine watchdog enabled by defining LINE_SCHED_TIMEOUT_EN.
module line_sched
  import line_sched_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int XW             = XW_DEF,
  parameter int YW             = YW_DEF,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*XW-1:0] req_x0,
  input  logic [NREQ*XW-1:0] req_x1,
  input  logic [NREQ*YW-1:0] req_y0,
  input  logic [NREQ*YW-1:0] req_y1,
  output logic [NREQ-1:0]   ack,
  output logic              eng_go,
  output logic [XW-1:0]     eng_x0,
  output logic [XW-1:0]     eng_x1,
  output logic [YW-1:0]     eng_y0,
  output logic [YW-1:0]     eng_y1,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic              busy,
  output logic [7:0]        line_count,
  output logic              frame_overrun,
  output logic              timeout_err
);

  localparam int PW = $clog2(NREQ);

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   grant_reg, grant_next, arb_grant;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [XW-1:0]     x0_reg, x0_next, x1_reg, x1_next;
  logic [YW-1:0]     y0_reg, y0_next, y1_reg, y1_next;
  logic [7:0]        count_reg;
  logic              overrun_reg;
  logic              done_ok;
  logic              timeout_hit;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr_reg),
    .grant (arb_grant)
  );

`ifdef LINE_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wd_cnt_reg;
  logic          abort_reg;
  logic          terr_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    ptr_next    = ptr_reg;
    x0_next     = x0_reg;
    x1_next     = x1_reg;
    y0_next     = y0_reg;
    y1_next     = y1_reg;
    done_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: if (frame_start) state_next = ARB;
      ARB: begin
        if (|req) begin
          grant_next = arb_grant;
          for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
              x0_next  = req_x0[i*XW +: XW];
              x1_next  = req_x1[i*XW +: XW];
              y0_next  = req_y0[i*YW +: YW];
              y1_next  = req_y1[i*YW +: YW];
              // Next search begins just past the winner, wrapping to 0.
              ptr_next = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
          end
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (eng_done) begin
          done_ok    = 1'b1;
          state_next = ACK;
        end
`ifdef LINE_SCHED_TIMEOUT_EN
        else if (wd_cnt_reg == WD_LAST) begin
          timeout_hit = 1'b1;
          state_next  = ACK;
        end
`endif
      end
      ACK:     state_next = ARB;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ptr_reg     <= '0;
      x0_reg      <= '0;
      x1_reg      <= '0;
      y0_reg      <= '0;
      y1_reg      <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      x0_reg      <= x0_next;
      x1_reg      <= x1_next;
      y0_reg      <= y0_next;
      y1_reg      <= y1_next;
      overrun_reg <= frame_start && (state_reg != IDLE);
      // A completion landing with frame_start belongs to the new frame.
      if (frame_start)
        count_reg <= done_ok ? 8'd1 : 8'd0;
      else if (done_ok && count_reg != 8'd255)
        count_reg <= count_reg + 8'd1;
    end
  end

`ifdef LINE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      abort_reg  <= 1'b0;
      terr_reg   <= 1'b0;
    end else begin
      wd_cnt_reg <= (state_reg == WAIT) ? wd_cnt_reg + 1'b1 : '0;
      abort_reg  <= timeout_hit;
      if (timeout_hit) terr_reg <= 1'b1;
    end
  end
  assign eng_abort   = abort_reg;
  assign timeout_err = terr_reg;
`else
  assign eng_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack           = (state_reg == ACK) ? grant_reg : '0;
  assign eng_go        = (state_reg == ISSUE);
  assign busy          = (state_reg != IDLE);
  assign eng_x0        = x0_reg;
  assign eng_x1        = x1_reg;
  assign eng_y0        = y0_reg;
  assign eng_y1        = y1_reg;
  assign line_count    = count_reg;
  assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_line_sched.sv
// Directed self-checking bench for line_sched; the timeout scenario follows
// the LINE_SCHED_TIMEOUT_EN build option.
module tb_line_sched;

  localparam int NREQ = 4;
  localparam int XW   = 11;
  localparam int YW   = 10;

  logic              clk = 1'b0;
  logic              reset, frame_start, eng_done;
  logic [NREQ-1:0]   req;
  logic [NREQ*XW-1:0] req_x0, req_x1;
  logic [NREQ*YW-1:0] req_y0, req_y1;
  logic [NREQ-1:0]   ack;
  logic              eng_go, eng_abort, busy, frame_overrun, timeout_err;
  logic [XW-1:0]     eng_x0, eng_x1;
  logic [YW-1:0]     eng_y0, eng_y1;
  logic [7:0]        line_count;

  int checks   = 0;
  int failures = 0;

  line_sched #(.NREQ(NREQ), .XW(XW), .YW(YW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .req(req),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1),
    .ack(ack), .eng_go(eng_go), .eng_x0(eng_x0), .eng_x1(eng_x1),
    .eng_y0(eng_y0), .eng_y1(eng_y1), .eng_done(eng_done),
    .eng_abort(eng_abort), .busy(busy), .line_count(line_count),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Requester i draws (100+i,200+i)->(300+i,400+i).
  task automatic load_endpoints;
    for (int i = 0; i < NREQ; i++) begin
      req_x0[i*XW +: XW] = XW'(100 + i);
      req_y0[i*YW +: YW] = YW'(200 + i);
      req_x1[i*XW +: XW] = XW'(300 + i);
      req_y1[i*YW +: YW] = YW'(400 + i);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1; frame_start = 1'b0; eng_done = 1'b0; req = '0;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL rst_ack got=%b exp=0000", ack); end
    checks++; if (eng_go !== 1'b0) begin failures++; $display("FAIL rst_eng_go got=%b exp=0", eng_go); end
    checks++; if (eng_abort !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rst_abort_terr got=%b%b exp=00", eng_abort, timeout_err); end
    checks++; if (line_count !== 8'd0) begin failures++; $display("FAIL rst_line_count got=%0d exp=0", line_count); end
    checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", frame_overrun); end
    checks++; if ({eng_x0, eng_y0, eng_x1, eng_y1} !== '0) begin failures++; $display("FAIL rst_endpoints got=%0d,%0d,%0d,%0d exp=0,0,0,0", eng_x0, eng_y0, eng_x1, eng_y1); end
  endtask

  task automatic test_single_line;
    do_reset;
    load_endpoints;
    req_x0[0 +: XW] = 11'd10;  req_y0[0 +: YW] = 10'd20;
    req_x1[0 +: XW] = 11'd100; req_y1[0 +: YW] = 10'd50;
    req = 4'b0001; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    checks++; if (busy !== 1'b1 || eng_go !== 1'b0) begin failures++; $display("FAIL sl_arb busy/go got=%b%b exp=10", busy, eng_go); end
    tick;                                           // ISSUE
    checks++; if (eng_go !== 1'b1) begin failures++; $display("FAIL sl_eng_go got=%b exp=1", eng_go); end
    checks++; if (eng_x0 !== 11'd10 || eng_y0 !== 10'd20 || eng_x1 !== 11'd100 || eng_y1 !== 10'd50) begin
      failures++; $display("FAIL sl_endpoints got=%0d,%0d,%0d,%0d exp=10,20,100,50", eng_x0, eng_y0, eng_x1, eng_y1); end
    tick;                                           // WAIT
    checks++; if (eng_go !== 1'b0 || ack !== 4'b0000) begin failures++; $display("FAIL sl_wait go/ack got=%b/%b exp=0/0000", eng_go, ack); end
    eng_done = 1'b1;
    tick; eng_done = 1'b0;                          // ACK
    checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL sl_ack got=%b exp=0001", ack); end
    checks++; if (line_count !== 8'd1) begin failures++; $display("FAIL sl_line_count got=%0d exp=1", line_count); end
    req = 4'b0000;
    tick;                                           // ARB
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL sl_ack_pulse got=%b exp=0000", ack); end
    tick;                                           // IDLE
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sl_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_fairness;
    logic [NREQ-1:0] exp_ack;
    int g;
    do_reset;
    load_endpoints;
    req = 4'b1111; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    for (int k = 0; k < 5; k++) begin
      g = k % NREQ;
      exp_ack = 4'b0001 << g;
      tick;                                         // ISSUE
      checks++; if (eng_go !== 1'b1 || eng_x0 !== XW'(100 + g) || eng_y1 !== YW'(400 + g)) begin
        failures++; $display("FAIL rr_issue%0d go=%b x0=%0d y1=%0d exp go=1 x0=%0d y1=%0d", k, eng_go, eng_x0, eng_y1, 100 + g, 400 + g); end
      tick;                                         // WAIT
      eng_done = 1'b1;
      tick; eng_done = 1'b0;                        // ACK
      checks++; if (ack !== exp_ack) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", k, ack, exp_ack); end
      if (k == 4) req = '0; else req[g] = 1'b0;
      tick;                                         // ARB
      if (k < 4) req[g] = 1'b1;
    end
    tick;                                           // IDLE
    checks++; if (busy !== 1'b0 || line_count !== 8'd5) begin failures++; $display("FAIL rr_end busy=%b count=%0d exp busy=0 count=5", busy, line_count); end
  endtask

  task automatic test_empty_frame;
    // line_count is 5 from the previous frame; frame_start must clear it.
    frame_start = 1'b1; req = '0;
    tick; frame_start = 1'b0;                       // ARB
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ef_arb busy got=%b exp=1", busy); end
    tick;                                           // IDLE
    checks++; if (busy !== 1'b0 || line_count !== 8'd0) begin failures++; $display("FAIL ef_idle busy=%b count=%0d exp busy=0 count=0", busy, line_count); end
  endtask

  task automatic test_overrun;
    do_reset;
    load_endpoints;
    req = 4'b0001; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    tick; tick;                                     // ISSUE, WAIT
    frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // still WAIT
    checks++; if (frame_overrun !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ov_pulse overrun=%b busy=%b exp 1,1", frame_overrun, busy); end
    eng_done = 1'b1;
    tick; eng_done = 1'b0;                          // ACK
    checks++; if (frame_overrun !== 1'b0) begin failures++; $display("FAIL ov_pulse_width got=%b exp=0", frame_overrun); end
    checks++; if (ack !== 4'b0001 || line_count !== 8'd1) begin failures++; $display("FAIL ov_done ack=%b count=%0d exp ack=0001 count=1", ack, line_count); end
    req = '0;
    tick; tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    load_endpoints;
    req = 4'b0011; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    tick; tick;                                     // ISSUE, WAIT
    eng_done = 1'b1;
    tick; eng_done = 1'b0;                          // ACK line 0
    checks++; if (ack !== 4'b0001 || line_count !== 8'd1) begin failures++; $display("FAIL bb_first ack=%b count=%0d exp ack=0001 count=1", ack, line_count); end
    req = 4'b0010;
    tick; tick;                                     // ARB, ISSUE
    checks++; if (eng_x0 !== 11'd101 || eng_y0 !== 10'd201) begin failures++; $display("FAIL bb_endpoints x0=%0d y0=%0d exp 101,201", eng_x0, eng_y0); end
    tick;                                           // WAIT
    frame_start = 1'b1; eng_done = 1'b1;
    tick; frame_start = 1'b0; eng_done = 1'b0;      // ACK line 1
    checks++; if (ack !== 4'b0010 || line_count !== 8'd1 || frame_overrun !== 1'b1) begin
      failures++; $display("FAIL bb_same_cycle ack=%b count=%0d overrun=%b exp ack=0010 count=1 overrun=1", ack, line_count, frame_overrun); end
    req = '0;
    tick; tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bb_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout;
    do_reset;
    load_endpoints;
    req = 4'b0001; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    tick; tick;                                     // ISSUE, first WAIT cycle
    for (int i = 0; i < 15; i++) tick;              // WAIT cycles 2..16
    checks++; if (ack !== 4'b0000 || eng_abort !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL to_waiting ack=%b abort=%b busy=%b exp 0000,0,1", ack, eng_abort, busy); end
`ifdef LINE_SCHED_TIMEOUT_EN
    tick;                                           // ACK via watchdog
    checks++; if (eng_abort !== 1'b1 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_abort abort=%b terr=%b exp 1,1", eng_abort, timeout_err); end
    checks++; if (ack !== 4'b0001 || line_count !== 8'd0) begin failures++; $display("FAIL to_ack ack=%b count=%0d exp ack=0001 count=0", ack, line_count); end
    req = '0;
    tick;
    checks++; if (eng_abort !== 1'b0 || timeout_err !== 1'b1) begin failures++; $display("FAIL to_sticky abort=%b terr=%b exp 0,1", eng_abort, timeout_err); end
    tick;
`else
    for (int i = 0; i < 10; i++) tick;
    checks++; if (eng_abort !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
      failures++; $display("FAIL to_disabled abort=%b terr=%b busy=%b ack=%b exp 0,0,1,0000", eng_abort, timeout_err, busy, ack); end
    eng_done = 1'b1;
    tick; eng_done = 1'b0;
    checks++; if (ack !== 4'b0001 || line_count !== 8'd1) begin failures++; $display("FAIL to_late_done ack=%b count=%0d exp ack=0001 count=1", ack, line_count); end
    req = '0;
    tick; tick;
`endif
  endtask

  task automatic test_midline_reset;
    load_endpoints;
    req = 4'b0011; frame_start = 1'b1;
    tick; frame_start = 1'b0;                       // ARB
    tick; tick;                                     // ISSUE, WAIT
    eng_done = 1'b1;
    tick; eng_done = 1'b0;                          // ACK line 0
    req = 4'b0010;
    tick; tick; tick;                               // ARB, ISSUE, WAIT line 1
    reset = 1'b1;
    tick; reset = 1'b0;
    checks++; if (busy !== 1'b0 || ack !== 4'b0000 || eng_go !== 1'b0 || eng_abort !== 1'b0) begin
      failures++; $display("FAIL mr_ctrl busy=%b ack=%b go=%b abort=%b exp 0,0000,0,0", busy, ack, eng_go, eng_abort); end
    checks++; if (line_count !== 8'd0 || timeout_err !== 1'b0 || eng_x0 !== 11'd0 || eng_y1 !== 10'd0) begin
      failures++; $display("FAIL mr_state count=%0d terr=%b x0=%0d y1=%0d exp 0,0,0,0", line_count, timeout_err, eng_x0, eng_y1); end
    req = '0; eng_done = 1'b1;
    tick; eng_done = 1'b0;
    checks++; if (ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL mr_late_done ack=%b busy=%b exp 0000,0", ack, busy); end
    tick;
    checks++; if (ack !== 4'b0000 || line_count !== 8'd0) begin failures++; $display("FAIL mr_after ack=%b count=%0d exp 0000,0", ack, line_count); end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; eng_done = 1'b0; req = '0;
    req_x0 = '0; req_x1 = '0; req_y0 = '0; req_y1 = '0;
    test_reset;
    test_single_line;
    test_fairness;
    test_empty_frame;
    test_overrun;
    test_back_to_back;
    test_timeout;
    test_midline_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
